// File: rtl/ccd_clock_sequencer_pkg.sv
// Shared types and constants for the CCD clock sequencer.
package ccd_seq_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_XFER  = 3'd1,
        GAP     = 3'd2,
        READOUT = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Serial half-pixel phase: A drives l1 low, B returns l1 high
    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

    // Clock levels whenever the sequencer is not actively clocking
    localparam logic IDLE_PHI_P  = 1'b0;
    localparam logic IDLE_PHI_L1 = 1'b1;
    localparam logic IDLE_PHI_L2 = 1'b0;

    // Largest of the three interval lengths, used to size the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/ccd_clock_sequencer_timer.sv
// Loadable down-counter; o_tc flags that the loaded interval has expired.
module ccd_seq_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count down from the loaded value and park at zero
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/ccd_clock_sequencer.sv
// Frame-level CCD clock sequencer: parallel transfer, settle gap and serial
// readout per line, repeated for every line of the frame.
module ccd_clock_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int PIX_PER_LINE    = 16,
    parameter int LINES_PER_FRAME = 4,
    parameter int P_CYC           = 3,
    parameter int GAP_CYC         = 2,
    parameter int PHASE_CYC       = 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic                               i_continuous,
    input  logic                               i_abort,
    output logic                               o_phi_p,
    output logic                               o_phi_l1,
    output logic                               o_phi_l2,
    output logic                               o_enable,
    output logic [$clog2(LINES_PER_FRAME)-1:0] o_line_idx,
    output logic [$clog2(PIX_PER_LINE)-1:0]    o_pix_idx,
    output logic                               o_busy,
    output logic                               o_frame_done
);

    localparam int CW = $clog2(max3(P_CYC, GAP_CYC, PHASE_CYC) + 1);
    localparam int LW = $clog2(LINES_PER_FRAME);
    localparam int PW = $clog2(PIX_PER_LINE);

    // Timer reload values: the interval ends on the cycle the count hits zero
    localparam logic [CW-1:0] LD_P  = CW'(P_CYC - 1);
    localparam logic [CW-1:0] LD_G  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] LD_PH = CW'(PHASE_CYC - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES_PER_FRAME - 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(PIX_PER_LINE - 1);

    state_e        r_state, w_state;
    phase_e        r_phase, w_phase;
    logic [LW-1:0] r_line, w_line;
    logic [PW-1:0] r_pix, w_pix;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_tc;
    logic          w_phi_p, w_l1;

    ccd_seq_timer #(.W(CW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // Next-state, index and timer-load decode; abort overrides everything
    always_comb begin
        w_state    = r_state;
        w_phase    = r_phase;
        w_line     = r_line;
        w_pix      = r_pix;
        w_load     = 1'b0;
        w_load_val = '0;
        if (i_abort) begin
            w_state = IDLE;
            w_phase = PH_B;
            w_line  = '0;
            w_pix   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_state    = P_XFER;
                        w_line     = '0;
                        w_load     = 1'b1;
                        w_load_val = LD_P;
                    end else begin
                        w_state = IDLE;
                    end
                end
                P_XFER: begin
                    if (w_tc) begin
                        w_state    = GAP;
                        w_load     = 1'b1;
                        w_load_val = LD_G;
                    end else begin
                        w_state = P_XFER;
                    end
                end
                GAP: begin
                    if (w_tc) begin
                        w_state    = READOUT;
                        w_phase    = PH_A;
                        w_pix      = '0;
                        w_load     = 1'b1;
                        w_load_val = LD_PH;
                    end else begin
                        w_state = GAP;
                    end
                end
                READOUT: begin
                    if (!w_tc) begin
                        w_state = READOUT;
                    end else if (r_phase == PH_A) begin
                        w_phase    = PH_B;
                        w_load     = 1'b1;
                        w_load_val = LD_PH;
                    end else if (r_pix != LAST_PIX) begin
                        w_pix      = r_pix + PW'(1);
                        w_phase    = PH_A;
                        w_load     = 1'b1;
                        w_load_val = LD_PH;
                    end else begin
                        w_pix   = '0;
                        w_phase = PH_B;
                        if (r_line != LAST_LINE) begin
                            w_line     = r_line + LW'(1);
                            w_state    = P_XFER;
                            w_load     = 1'b1;
                            w_load_val = LD_P;
                        end else begin
                            w_state = DONE;
                        end
                    end
                end
                DONE: begin
                    w_line = '0;
                    if (i_continuous) begin
                        w_state    = P_XFER;
                        w_load     = 1'b1;
                        w_load_val = LD_P;
                    end else begin
                        w_state = IDLE;
                    end
                end
                default: begin
                    w_state = IDLE;
                    w_phase = PH_B;
                    w_line  = '0;
                    w_pix   = '0;
                end
            endcase
        end
    end

    // Clock levels decoded from the upcoming state so outputs align with it
    always_comb begin
        w_phi_p = IDLE_PHI_P;
        w_l1    = IDLE_PHI_L1;
        if (w_state == P_XFER) begin
            w_phi_p = 1'b1;
        end else if (w_state == READOUT && w_phase == PH_A) begin
            w_l1 = 1'b0;
        end else begin
            w_phi_p = IDLE_PHI_P;
            w_l1    = IDLE_PHI_L1;
        end
    end

    // State, index and registered-output update with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_phase      <= PH_B;
            r_line       <= '0;
            r_pix        <= '0;
            o_phi_p      <= IDLE_PHI_P;
            o_phi_l1     <= IDLE_PHI_L1;
            o_phi_l2     <= IDLE_PHI_L2;
            o_enable     <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_line_idx   <= '0;
            o_pix_idx    <= '0;
        end else begin
            r_state      <= w_state;
            r_phase      <= w_phase;
            r_line       <= w_line;
            r_pix        <= w_pix;
            o_phi_p      <= w_phi_p;
            o_phi_l1     <= w_l1;
            o_phi_l2     <= ~w_l1;
            o_enable     <= (w_state == READOUT);
            o_busy       <= (w_state != IDLE);
            o_frame_done <= (w_state == DONE);
            o_line_idx   <= w_line;
            o_pix_idx    <= w_pix;
        end
    end

endmodule

// File: tb/tb_ccd_clock_sequencer.sv
// Self-checking bench: vector table, frame-level sequences and random
// stimulus against a cycle-offset model of the frame timeline.
module tb_ccd_clock_sequencer;

    localparam int P = 3;
    localparam int G = 2;
    localparam int L = 4;
    localparam int FA = L * (P + G + 2 * 1 * 16) + 1;
    localparam int FB = L * (P + G + 2 * 2 * 4) + 1;

    // Packed view: {phi_p, l1, l2, enable, busy, frame_done, line[3:0], pix[3:0]}
    localparam logic [13:0] EX_IDLE = {6'b010000, 8'h00};
    localparam logic [13:0] EX_PX   = {6'b110010, 8'h00};
    localparam logic [13:0] EX_GAP  = {6'b010010, 8'h00};
    localparam logic [13:0] EX_RA0  = {6'b001110, 8'h00};
    localparam logic [13:0] EX_RB0  = {6'b010110, 8'h00};
    localparam logic [13:0] EX_RA1  = {6'b001110, 8'h01};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, cont, abort;
    logic phi_p_a, l1_a, l2_a, en_a, busy_a, done_a;
    logic [1:0] line_a;
    logic [3:0] pix_a;
    logic phi_p_b, l1_b, l2_b, en_b, busy_b, done_b;
    logic [1:0] line_b;
    logic [1:0] pix_b;
    logic [13:0] w_a, w_b;

    assign w_a = {phi_p_a, l1_a, l2_a, en_a, busy_a, done_a, 2'b00, line_a, pix_a};
    assign w_b = {phi_p_b, l1_b, l2_b, en_b, busy_b, done_b, 2'b00, line_b, 2'b00, pix_b};

    ccd_clock_sequencer dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont),
        .i_abort(abort), .o_phi_p(phi_p_a), .o_phi_l1(l1_a), .o_phi_l2(l2_a),
        .o_enable(en_a), .o_line_idx(line_a), .o_pix_idx(pix_a),
        .o_busy(busy_a), .o_frame_done(done_a)
    );

    ccd_clock_sequencer #(.PIX_PER_LINE(4), .PHASE_CYC(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont),
        .i_abort(abort), .o_phi_p(phi_p_b), .o_phi_l1(l1_b), .o_phi_l2(l2_b),
        .o_enable(en_b), .o_line_idx(line_b), .o_pix_idx(pix_b),
        .o_busy(busy_b), .o_frame_done(done_b)
    );

    int n_total = 0;
    int n_bad   = 0;
    bit ma_act = 1'b0;
    bit mb_act = 1'b0;
    int ma_k = 0;
    int mb_k = 0;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        cont;
        logic        abort;
        logic [13:0] exp;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the position k within a frame
    function automatic logic [13:0] model_out(input int ppl, input int ph, input bit act, input int k);
        int ll, fl, ln, r, q, px;
        bit a;
        ll = P + G + 2 * ph * ppl;
        fl = L * ll + 1;
        if (!act) return EX_IDLE;
        if (k == fl - 1) return {6'b010011, 4'(L - 1), 4'd0};
        ln = k / ll;
        r  = k % ll;
        if (r < P) return {6'b110010, 4'(ln), 4'd0};
        if (r < P + G) return {6'b010010, 4'(ln), 4'd0};
        q  = r - P - G;
        px = q / (2 * ph);
        a  = (q % (2 * ph)) < ph;
        return {1'b0, ~a, a, 3'b110, 4'(ln), 4'(px)};
    endfunction

    task automatic mdl_step(input int frame, inout bit act, inout int k);
        if (!rst_n || abort) begin
            act = 1'b0;
        end else if (!act) begin
            if (start) begin
                act = 1'b1;
                k = 0;
            end
        end else if (k == frame - 1) begin
            if (cont) k = 0;
            else act = 1'b0;
        end else begin
            k++;
        end
        if (!act) k = 0;
    endtask

    task automatic step();
        @(posedge clk);
        mdl_step(FA, ma_act, ma_k);
        mdl_step(FB, mb_act, mb_k);
        #1;
        chk("model_a", w_a, model_out(16, 1, ma_act, ma_k));
        chk("model_b", w_b, model_out(4, 2, mb_act, mb_k));
    endtask

    int done_at, done_cnt, phi_hi, l2_rises, b_rise, b_done;
    bit prev_l2, prev_pb, prev_done, found;
    int d[2];
    int nd;

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, EX_IDLE};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, EX_IDLE};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, EX_IDLE};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, EX_IDLE};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, EX_PX};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, EX_PX};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, EX_PX};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, EX_GAP};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, EX_GAP};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, EX_RA0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, EX_RB0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, EX_RA1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, EX_IDLE};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, EX_PX};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, EX_IDLE};

        for (int i = 0; i < 15; i++) begin
            rst_n = vecs[i].rst_n; start = vecs[i].start;
            cont = vecs[i].cont; abort = vecs[i].abort;
            step();
            chk($sformatf("vec%0d", i), w_a, vecs[i].exp);
        end

        // Hold reset released for 10 cycles with no request
        rst_n = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("reset_hold", w_a, EX_IDLE);

        // Single frame, with stray start pulses during the frame
        start = 1'b1;
        step();
        start = 1'b0;
        done_at = -1; done_cnt = 0; phi_hi = 1; l2_rises = 0; b_rise = -1; b_done = -1;
        prev_l2 = l2_a; prev_pb = phi_p_b;
        for (int i = 1; i < 400; i++) begin
            start = (i % 10 == 0);
            step();
            if (phi_p_a) phi_hi++;
            if (l2_a && !prev_l2) l2_rises++;
            if (phi_p_b && !prev_pb && b_rise < 0) b_rise = i;
            if (done_b && b_done < 0) b_done = i;
            if (done_a) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            prev_l2 = l2_a; prev_pb = phi_p_b;
            if (!busy_a) break;
        end
        start = 1'b0;
        chk_int("frame_done_at", done_at, FA - 1);
        chk_int("frame_done_cnt", done_cnt, 1);
        chk_int("phi_p_high_cycles", phi_hi, L * P);
        chk_int("l2_pulses", l2_rises, L * 16);
        chk_int("b_line_len", b_rise, 21);
        chk_int("b_frame_done_at", b_done, FB - 1);
        chk("after_frame_idle", w_a, EX_IDLE);

        // Continuous mode: back-to-back frames
        cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        nd = 0; prev_done = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (prev_done) chk_int("cont_restart", int'(phi_p_a), 1);
            if (done_a && nd < 2) begin
                d[nd] = i;
                nd++;
            end
            prev_done = done_a;
        end
        chk_int("cont_frames", nd, 2);
        if (nd == 2) chk_int("cont_period", d[1] - d[0], FA);
        cont = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!busy_a) begin
                found = 1'b1;
                break;
            end
        end
        chk_int("cont_stop", int'(found), 1);

        // Abort in READOUT on line 2, pixel 7
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (line_a == 2'd2 && pix_a == 4'd7 && en_a) begin
                found = 1'b1;
                break;
            end
        end
        chk_int("abort_reach", int'(found), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", w_a, EX_IDLE);
        done_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done_a) done_cnt++;
        end
        chk_int("abort_no_done", done_cnt, 0);

        // Random stimulus against the frame model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 99) == 0);
            cont  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
